ps2_key_event_gen: RTL and testbench

PS2_KEY_EVENT_GEN -- requirements
Module: ps2_key_event_gen

---
 rtl/ps2_key_event_gen.sv | 187 ++++++++++++++++++
 tb/tb_ps2_key_event_gen.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_key_event_gen.sv
// rtl/ps2_key_event_gen.sv - PS/2 keyboard frame receiver and key event decoder
module ps2_key_event_gen #(
    parameter int FILTER_LEN = 8,
    parameter int TIMEOUT    = 24000
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    output logic [10:0] ps2_key,
    output logic        frame_err
);

    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t        state;
    state_t        state_n;

    logic [1:0]    clk_pipe;
    logic [1:0]    data_pipe;
    logic          clk_s;
    logic          data_s;

    logic          filt_clk;
    logic [FW-1:0] filt_cnt;
    logic          fall;
    logic          data_smp;

    logic [2:0]    bit_cnt;
    logic [7:0]    shift;
    logic          par_ok;
    logic [TW-1:0] to_cnt;

    logic          byte_done;
    logic          frame_bad;
    logic          timeout_hit;
    logic          is_status;

    logic          ext;
    logic          brk;
    logic [2:0]    skip_cnt;

    // Idle bus level is high, so synchronizers come out of reset at 1.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            clk_pipe  <= 2'b11;
            data_pipe <= 2'b11;
        end else begin
            clk_pipe  <= {clk_pipe[0], ps2_clk};
            data_pipe <= {data_pipe[0], ps2_data};
        end
    end

    assign clk_s  = clk_pipe[1];
    assign data_s = data_pipe[1];

    // Filtered clock flips after FILTER_LEN samples in a row disagree with it;
    // data is captured at the same moment a falling transition is accepted.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            filt_clk <= 1'b1;
            filt_cnt <= '0;
            fall     <= 1'b0;
            data_smp <= 1'b1;
        end else begin
            fall <= 1'b0;
            if (clk_s == filt_clk) begin
                filt_cnt <= '0;
            end else if (filt_cnt == FW'(FILTER_LEN - 1)) begin
                filt_clk <= clk_s;
                filt_cnt <= '0;
                if (!clk_s) begin
                    fall     <= 1'b1;
                    data_smp <= data_s;
                end
            end else begin
                filt_cnt <= filt_cnt + FW'(1);
            end
        end
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n     = state;
        byte_done   = 1'b0;
        frame_bad   = 1'b0;
        timeout_hit = (state != S_IDLE) && !fall && (to_cnt == TW'(TIMEOUT));
        if (timeout_hit) begin
            state_n = S_IDLE;
        end else if (fall) begin
            case (state)
                S_IDLE:   if (!data_smp) state_n = S_DATA;
                S_DATA:   if (bit_cnt == 3'd7) state_n = S_PARITY;
                S_PARITY: state_n = S_STOP;
                S_STOP: begin
                    state_n = S_IDLE;
                    if (par_ok && data_smp) begin
                        byte_done = 1'b1;
                    end else begin
                        frame_bad = 1'b1;
                    end
                end
                default:  state_n = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            bit_cnt <= 3'd0;
            shift   <= 8'h00;
            par_ok  <= 1'b0;
            to_cnt  <= '0;
        end else begin
            if (fall || timeout_hit || state == S_IDLE) begin
                to_cnt <= '0;
            end else begin
                to_cnt <= to_cnt + TW'(1);
            end
            if (fall) begin
                case (state)
                    S_IDLE: bit_cnt <= 3'd0;
                    S_DATA: begin
                        shift   <= {data_smp, shift[7:1]};
                        bit_cnt <= bit_cnt + 3'd1;
                    end
                    S_PARITY: par_ok <= (^shift) ^ data_smp;
                    default: ;
                endcase
            end
        end
    end

    assign is_status = (shift == 8'h00) || (shift == 8'hAA) || (shift == 8'hEE) ||
                       (shift == 8'hFA) || (shift == 8'hFE) || (shift == 8'hFF);

    // Byte interpretation: pause-sequence skipping, prefix flags, then events.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            ps2_key   <= 11'h000;
            frame_err <= 1'b0;
            ext       <= 1'b0;
            brk       <= 1'b0;
            skip_cnt  <= 3'd0;
        end else begin
            frame_err <= frame_bad | timeout_hit;
            if (frame_bad || timeout_hit) begin
                ext <= 1'b0;
                brk <= 1'b0;
            end else if (byte_done) begin
                if (skip_cnt != 3'd0) begin
                    skip_cnt <= skip_cnt - 3'd1;
                end else if (shift == 8'hE1) begin
                    skip_cnt <= 3'd7;
                    ext      <= 1'b0;
                    brk      <= 1'b0;
                end else if (shift == 8'hE0) begin
                    ext <= 1'b1;
                end else if (shift == 8'hF0) begin
                    brk <= 1'b1;
                end else begin
                    ext <= 1'b0;
                    brk <= 1'b0;
                    if (!is_status) begin
                        ps2_key <= {~ps2_key[10], ~brk, ext, shift};
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_ps2_key_event_gen.sv
// tb/tb_ps2_key_event_gen.sv - bench for ps2_key_event_gen against a byte-level reference model
module tb_ps2_key_event_gen;

    localparam int FILTER_LEN = 8;
    localparam int TIMEOUT    = 600;

    logic        clk_sys  = 1'b0;
    logic        reset    = 1'b1;
    logic        ps2_clk  = 1'b1;
    logic        ps2_data = 1'b1;
    logic [10:0] ps2_key;
    logic        frame_err;

    ps2_key_event_gen #(.FILTER_LEN(FILTER_LEN), .TIMEOUT(TIMEOUT)) dut (
        .clk_sys  (clk_sys),
        .reset    (reset),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .ps2_key  (ps2_key),
        .frame_err(frame_err)
    );

    always #5 clk_sys = ~clk_sys;

    int checks = 0;
    int errors = 0;

    logic [9:0] ev_q[$];
    logic [9:0] exp_q[$];
    int n_ferr  = 0;
    int n_long  = 0;
    int n_coinc = 0;
    logic prev_tog  = 1'b0;
    logic prev_ferr = 1'b0;

    bit m_tog;
    bit m_ext;
    bit m_brk;
    int m_skip;

    always @(negedge clk_sys) begin
        if (reset) begin
            prev_tog  = ps2_key[10];
            prev_ferr = 1'b0;
        end else begin
            if (ps2_key[10] !== prev_tog) begin
                ev_q.push_back(ps2_key[9:0]);
                if (frame_err) n_coinc++;
            end
            if (frame_err) begin
                n_ferr++;
                if (prev_ferr) n_long++;
            end
            prev_tog  = ps2_key[10];
            prev_ferr = frame_err;
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached, errors so far %0d", errors);
        $fatal(1, "watchdog");
    end

    function automatic void model_reset();
        m_tog = 0; m_ext = 0; m_brk = 0; m_skip = 0;
    endfunction

    function automatic void model_err();
        m_ext = 0; m_brk = 0;
    endfunction

    function automatic void model_byte(input logic [7:0] b);
        if (m_skip > 0) begin
            m_skip--;
        end else if (b == 8'hE1) begin
            m_skip = 7; m_ext = 0; m_brk = 0;
        end else if (b == 8'hE0) begin
            m_ext = 1;
        end else if (b == 8'hF0) begin
            m_brk = 1;
        end else if (b inside {8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF}) begin
            m_ext = 0; m_brk = 0;
        end else begin
            exp_q.push_back({~m_brk, m_ext, b});
            m_tog = ~m_tog;
            m_ext = 0; m_brk = 0;
        end
    endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge clk_sys);
    endtask

    task automatic ps2_bit(input bit v);
        ps2_data = v;
        tick(10);
        ps2_clk = 1'b0;
        tick(20);
        ps2_clk = 1'b1;
        tick(20);
    endtask

    // Sends the first nbits of a frame; a short low glitch follows bit glitch_at.
    task automatic send_frame(input logic [7:0] b, input bit bad_par, input int nbits, input int glitch_at);
        logic [10:0] fr;
        fr = {1'b1, (~^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            ps2_bit(fr[i]);
            if (i == glitch_at) begin
                ps2_data = ~fr[i];
                tick(5);
                ps2_clk = 1'b0;
                tick(3);
                ps2_clk = 1'b1;
                tick(20);
            end
        end
        ps2_data = 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        send_frame(b, 1'b0, 11, -1);
        model_byte(b);
    endtask

    task automatic clear_obs();
        ev_q.delete();
        exp_q.delete();
        n_ferr = 0; n_long = 0; n_coinc = 0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        model_reset();
        tick(5);
        checks++;
        if (ps2_key !== 11'h000) begin errors++; $display("FAIL reset_key: got %h expected 000", ps2_key); end
        checks++;
        if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_ferr: got %b expected 0", frame_err); end
        reset = 1'b0;
        tick(20);
        checks++;
        if (ps2_key !== 11'h000 || frame_err !== 1'b0) begin
            errors++; $display("FAIL post_reset: key %h ferr %b expected 000 0", ps2_key, frame_err);
        end
    endtask

    task automatic test_single();
        clear_obs();
        send_byte(8'h1C);
        tick(20);
        checks++;
        if (ps2_key !== 11'h61C) begin errors++; $display("FAIL single_key: got %h expected 61c", ps2_key); end
        checks++;
        if (ev_q.size() !== 1) begin errors++; $display("FAIL single_toggles: got %0d expected 1", ev_q.size()); end
        checks++;
        if (n_ferr !== 0) begin errors++; $display("FAIL single_ferr: got %0d expected 0", n_ferr); end
    endtask

    task automatic test_prefix();
        clear_obs();
        send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h75);
        send_byte(8'hF0); send_byte(8'hE0); send_byte(8'h75);
        tick(20);
        checks++;
        if (ev_q.size() !== 2) begin errors++; $display("FAIL prefix_count: got %0d expected 2", ev_q.size()); end
        for (int i = 0; i < ev_q.size() && i < 2; i++) begin
            checks++;
            if (ev_q[i] !== 10'h175) begin errors++; $display("FAIL prefix_ev%0d: got %h expected 175", i, ev_q[i]); end
        end
        checks++;
        if (ps2_key[10] !== m_tog) begin errors++; $display("FAIL prefix_toggle: got %b expected %b", ps2_key[10], m_tog); end
    endtask

    task automatic test_parity();
        clear_obs();
        send_frame(8'h29, 1'b1, 11, -1);
        model_err();
        tick(20);
        checks++;
        if (n_ferr !== 1 || n_long !== 0) begin
            errors++; $display("FAIL parity_ferr: got %0d pulses (%0d long) expected 1 (0)", n_ferr, n_long);
        end
        checks++;
        if (ev_q.size() !== 0) begin errors++; $display("FAIL parity_noevent: got %0d expected 0", ev_q.size()); end
        send_byte(8'h29);
        tick(20);
        checks++;
        if (ev_q.size() !== 1 || ps2_key[9:0] !== 10'h229) begin
            errors++; $display("FAIL parity_next: got %0d events key %h expected 1 229", ev_q.size(), ps2_key[9:0]);
        end
    endtask

    task automatic test_timeout();
        clear_obs();
        send_frame(8'h5A, 1'b0, 5, -1);
        tick(TIMEOUT + 10);
        model_err();
        checks++;
        if (n_ferr !== 1 || n_long !== 0) begin
            errors++; $display("FAIL timeout_ferr: got %0d pulses (%0d long) expected 1 (0)", n_ferr, n_long);
        end
        send_byte(8'h1B);
        tick(20);
        checks++;
        if (ev_q.size() !== 1 || ps2_key[9:0] !== 10'h21B) begin
            errors++; $display("FAIL timeout_next: got %0d events key %h expected 1 21b", ev_q.size(), ps2_key[9:0]);
        end
    endtask

    task automatic test_pause();
        logic [7:0] seq [9];
        seq = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77, 8'h16};
        clear_obs();
        for (int i = 0; i < 8; i++) send_byte(seq[i]);
        checks++;
        if (ev_q.size() !== 0) begin errors++; $display("FAIL pause_quiet: got %0d events expected 0", ev_q.size()); end
        send_byte(seq[8]);
        tick(20);
        checks++;
        if (ev_q.size() !== 1 || ps2_key[9:0] !== 10'h216) begin
            errors++; $display("FAIL pause_event: got %0d events key %h expected 1 216", ev_q.size(), ps2_key[9:0]);
        end
    endtask

    task automatic test_glitch();
        clear_obs();
        send_frame(8'h3A, 1'b0, 11, 3);
        model_byte(8'h3A);
        tick(20);
        checks++;
        if (n_ferr !== 0) begin errors++; $display("FAIL glitch_ferr: got %0d expected 0", n_ferr); end
        checks++;
        if (ev_q.size() !== 1 || ps2_key[9:0] !== exp_q[0]) begin
            errors++; $display("FAIL glitch_event: got %0d events key %h expected 1 %h", ev_q.size(), ps2_key[9:0], exp_q[0]);
        end
    endtask

    task automatic test_reset_mid();
        send_frame(8'h44, 1'b0, 4, -1);
        reset = 1'b1;
        tick(3);
        checks++;
        if (ps2_key !== 11'h000 || frame_err !== 1'b0) begin
            errors++; $display("FAIL midreset_hold: key %h ferr %b expected 000 0", ps2_key, frame_err);
        end
        reset = 1'b0;
        model_reset();
        clear_obs();
        tick(20);
        send_byte(8'h1C);
        tick(20);
        checks++;
        if (ps2_key !== 11'h61C || n_ferr !== 0) begin
            errors++; $display("FAIL midreset_next: key %h ferr %0d expected 61c 0", ps2_key, n_ferr);
        end
    endtask

    task automatic test_random();
        logic [7:0] b;
        clear_obs();
        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 9))
                0: b = 8'hE0;
                1: b = 8'hF0;
                2: b = ($urandom_range(0, 3) == 0) ? 8'hE1 : 8'hF0;
                3: b = 8'hFA;
                default: b = 8'($urandom_range(0, 255));
            endcase
            if ($urandom_range(0, 9) == 0) begin
                send_frame(b, 1'b1, 11, -1);
                model_err();
            end else begin
                send_byte(b);
            end
        end
        tick(20);
        checks++;
        if (ev_q.size() !== exp_q.size()) begin
            errors++; $display("FAIL random_count: got %0d events expected %0d", ev_q.size(), exp_q.size());
        end
        for (int i = 0; i < ev_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (ev_q[i] !== exp_q[i]) begin errors++; $display("FAIL random_ev%0d: got %h expected %h", i, ev_q[i], exp_q[i]); end
        end
        checks++;
        if (ps2_key[10] !== m_tog) begin errors++; $display("FAIL random_toggle: got %b expected %b", ps2_key[10], m_tog); end
    endtask

    task automatic test_pulse_rules();
        checks++;
        if (n_coinc !== 0 || n_long !== 0) begin
            errors++; $display("FAIL pulse_rules: coincident %0d long %0d expected 0 0", n_coinc, n_long);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_prefix();
        test_parity();
        test_timeout();
        test_pause();
        test_glitch();
        test_reset_mid();
        test_random();
        test_pulse_rules();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
